// File: rtl/srm_pkg.sv
// -----------------------------------------------------------------------------
// srm_pkg
// Shared definitions for the Simple RISC Machine controller slice:
//   - state_t      : sequencer state encoding
//   - instr_cls_t  : decoded instruction class
//   - OPC_* / OP_* : opcode and op-field constants
//   - ALU_*        : ALU operation encodings
//   - VSEL_*       : register file writeback source encodings
// -----------------------------------------------------------------------------
package srm_pkg;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_WR_IMM = 3'd2,
      S_GET_A  = 3'd3,
      S_GET_B  = 3'd4,
      S_ALU    = 3'd5,
      S_WR_REG = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CLS_ILLEGAL = 3'd0,
      CLS_MOV_IMM = 3'd1,
      CLS_MOV_REG = 3'd2,
      CLS_ALU     = 3'd3,   // ADD and AND: two operands, result written to Rd
      CLS_CMP     = 3'd4,
      CLS_MVN     = 3'd5
   } instr_cls_t;

   localparam logic [2:0] OPC_MOV    = 3'b110;
   localparam logic [2:0] OPC_ALU    = 3'b101;

   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_AND    = 2'b10;
   localparam logic [1:0] ALU_MVN    = 2'b11;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_IMM8  = 2'b01;

endpackage

// File: rtl/p4_instr_decode.sv
// -----------------------------------------------------------------------------
// p4_instr_decode
// Purely combinational instruction field extraction, sign extension of the
// 8-bit immediate and classification of the instruction.
// Configuration macro: SEQ_CMP_EN (when undefined, CMP decodes as illegal).
// Ports:
//   ir      in   DATA_W  latched instruction register
//   op      out  2       IR[12:11]
//   rn      out  REG_AW  IR[10:8]
//   rd      out  REG_AW  IR[7:5]
//   sh      out  2       IR[4:3]
//   rm      out  REG_AW  IR[2:0]
//   sximm8  out  DATA_W  IR[7:0] sign-extended
//   cls     out  3       instruction class (CLS_ILLEGAL when unsupported)
// -----------------------------------------------------------------------------
module p4_instr_decode
   import srm_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic [DATA_W-1:0] ir,
   output logic [1:0]        op,
   output logic [REG_AW-1:0] rn,
   output logic [REG_AW-1:0] rd,
   output logic [1:0]        sh,
   output logic [REG_AW-1:0] rm,
   output logic [DATA_W-1:0] sximm8,
   output instr_cls_t        cls
);

   logic [2:0] opc;

   assign opc    = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[8 +: REG_AW];
   assign rd     = ir[5 +: REG_AW];
   assign sh     = ir[4:3];
   assign rm     = ir[0 +: REG_AW];
   assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

   // NOTE: every signal written in always_comb gets a default first so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      cls = CLS_ILLEGAL;
      if (opc == OPC_MOV) begin
         if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
         else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
      end else if (opc == OPC_ALU) begin
         case (op)
            ALU_ADD, ALU_AND: cls = CLS_ALU;
            ALU_MVN:          cls = CLS_MVN;
            ALU_SUB: begin
`ifdef SEQ_CMP_EN
               cls = CLS_CMP;
`else
               cls = CLS_ILLEGAL;
`endif
            end
            default:          cls = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/p4_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// p4_regfile_sequencer
// Moore controller sequencing the 8x16 register file, A/B/C pipeline registers
// and ALU/shifter of the Simple RISC Machine datapath. One instruction is
// latched into IR on s&w, then the datapath strobes are stepped through.
// Configuration macro: SEQ_CMP_EN (enables CMP: GET_A -> GET_B -> ALU w/ loads).
// Ports:
//   clk       in   1       rising-edge clock
//   reset     in   1       asynchronous active-high reset
//   s         in   1       start strobe, sampled only in WAIT
//   in        in   DATA_W  instruction, latched into IR on s&w
//   w         out  1       idle in WAIT
//   err       out  1       high during DECODE of an unsupported instruction
//   readnum   out  REG_AW  register file read index
//   writenum  out  REG_AW  register file write index
//   write     out  1       register file write enable
//   loada/b/c out  1       pipeline register loads
//   loads     out  1       status register load
//   asel      out  1       force ALU A input to 0
//   bsel      out  1       ALU B = sximm5 (unused, tied 0)
//   vsel      out  2       writeback source select
//   shift     out  2       shifter op
//   ALUop     out  2       ALU op
//   sximm8    out  DATA_W  sign-extended IR[7:0]
// -----------------------------------------------------------------------------
module p4_regfile_sequencer
   import srm_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic [DATA_W-1:0] in,
   output logic              w,
   output logic              err,
   output logic [REG_AW-1:0] readnum,
   output logic [REG_AW-1:0] writenum,
   output logic              write,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [1:0]        vsel,
   output logic [1:0]        shift,
   output logic [1:0]        ALUop,
   output logic [DATA_W-1:0] sximm8
);

   state_t            state;
   logic [DATA_W-1:0] ir;

   logic [1:0]        op;
   logic [REG_AW-1:0] rn, rd, rm;
   logic [1:0]        sh;
   instr_cls_t        cls;

   p4_instr_decode #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_decode (
      .ir     (ir),
      .op     (op),
      .rn     (rn),
      .rd     (rd),
      .sh     (sh),
      .rm     (rm),
      .sximm8 (sximm8),
      .cls    (cls)
   );

   // State register and IR. IR only loads in WAIT, so it holds the current
   // instruction until the sequence completes regardless of `in`.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_WAIT;
         ir    <= '0;
      end else begin
         case (state)
            S_WAIT: begin
               if (s) begin
                  ir    <= in;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (cls)
                  CLS_MOV_IMM:          state <= S_WR_IMM;
                  CLS_MOV_REG, CLS_MVN: state <= S_GET_B;
                  CLS_ALU, CLS_CMP:     state <= S_GET_A;
                  default:              state <= S_WAIT;
               endcase
            end
            S_WR_IMM: state <= S_WAIT;
            S_GET_A:  state <= S_GET_B;
            S_GET_B:  state <= S_ALU;
            S_ALU:    state <= (cls == CLS_CMP) ? S_WAIT : S_WR_REG;
            S_WR_REG: state <= S_WAIT;
            default:  state <= S_WAIT;
         endcase
      end
   end

   // Moore outputs: functions of state and IR only, never of `in` or `s`.
   always_comb begin
      w        = 1'b0;
      err      = 1'b0;
      readnum  = '0;
      writenum = '0;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = VSEL_C;
      shift    = 2'b00;
      ALUop    = ALU_ADD;
      case (state)
         S_WAIT:   w = 1'b1;
         S_DECODE: err = (cls == CLS_ILLEGAL);
         S_WR_IMM: begin
            writenum = rn;
            vsel     = VSEL_IMM8;
            write    = 1'b1;
         end
         S_GET_A: begin
            readnum = rn;
            loada   = 1'b1;
         end
         S_GET_B: begin
            readnum = rm;
            loadb   = 1'b1;
         end
         S_ALU: begin
            shift = sh;
            // MOV reg passes B through ADD with A forced to 0.
            ALUop = (cls == CLS_MOV_REG) ? ALU_ADD : op;
            asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
            if (cls == CLS_CMP) loads = 1'b1;
            else                loadc = 1'b1;
         end
         S_WR_REG: begin
            writenum = rd;
            vsel     = VSEL_C;
            write    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_p4_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_p4_regfile_sequencer
// Self-checking bench. For each instruction a reference model pushes the
// expected per-cycle output vector sequence into a scoreboard queue; each
// cycle the front entry is popped and compared with the DUT outputs. The
// cycle at which w returns is compared against the documented latency.
// -----------------------------------------------------------------------------
module tb_p4_regfile_sequencer;

   typedef struct packed {
      logic        w;
      logic        err;
      logic [2:0]  readnum;
      logic [2:0]  writenum;
      logic        write;
      logic        loada;
      logic        loadb;
      logic        loadc;
      logic        loads;
      logic        asel;
      logic        bsel;
      logic [1:0]  vsel;
      logic [1:0]  shift;
      logic [1:0]  aluop;
      logic [15:0] sximm8;
   } obs_t;

`ifdef SEQ_CMP_EN
   localparam bit CMP_EN = 1'b1;
`else
   localparam bit CMP_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        s;
   logic [15:0] in;
   logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, shift, ALUop;
   logic [15:0] sximm8;

   int   n_cmp = 0;
   int   n_mis = 0;
   obs_t sb[$];

   p4_regfile_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .s        (s),
      .in       (in),
      .w        (w),
      .err      (err),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .bsel     (bsel),
      .vsel     (vsel),
      .shift    (shift),
      .ALUop    (ALUop),
      .sximm8   (sximm8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t observe();
      obs_t o;
      o.w        = w;
      o.err      = err;
      o.readnum  = readnum;
      o.writenum = writenum;
      o.write    = write;
      o.loada    = loada;
      o.loadb    = loadb;
      o.loadc    = loadc;
      o.loads    = loads;
      o.asel     = asel;
      o.bsel     = bsel;
      o.vsel     = vsel;
      o.shift    = shift;
      o.aluop    = ALUop;
      o.sximm8   = sximm8;
      return o;
   endfunction

   // Reference model of the expected cycle-by-cycle outputs, from DECODE
   // up to and including the first cycle back in WAIT.
   task automatic push_trace(input logic [15:0] instr);
      logic [2:0] opc;
      logic [1:0] op, sh;
      logic [2:0] rn, rd, rm;
      bit         mov_imm, mov_reg, alu, cmp, mvn, legal;
      obs_t       base, e;
      opc = instr[15:13];
      op  = instr[12:11];
      rn  = instr[10:8];
      rd  = instr[7:5];
      sh  = instr[4:3];
      rm  = instr[2:0];
      mov_imm = (opc == 3'b110) && (op == 2'b10);
      mov_reg = (opc == 3'b110) && (op == 2'b00);
      alu     = (opc == 3'b101);
      cmp     = alu && (op == 2'b01);
      mvn     = alu && (op == 2'b11);
      legal   = mov_imm || mov_reg || (alu && (!cmp || CMP_EN));
      base        = '0;
      base.sximm8 = {{8{instr[7]}}, instr[7:0]};
      e     = base;
      e.err = !legal;
      sb.push_back(e);
      if (legal) begin
         if (mov_imm) begin
            e = base; e.writenum = rn; e.vsel = 2'b01; e.write = 1'b1;
            sb.push_back(e);
         end else begin
            if (alu && !mvn) begin
               e = base; e.readnum = rn; e.loada = 1'b1;
               sb.push_back(e);
            end
            e = base; e.readnum = rm; e.loadb = 1'b1;
            sb.push_back(e);
            e = base; e.shift = sh;
            e.aluop = mov_reg ? 2'b00 : op;
            e.asel  = mov_reg || mvn;
            if (cmp) e.loads = 1'b1;
            else     e.loadc = 1'b1;
            sb.push_back(e);
            if (!cmp) begin
               e = base; e.writenum = rd; e.write = 1'b1;
               sb.push_back(e);
            end
         end
      end
      e = base; e.w = 1'b1;
      sb.push_back(e);
   endtask

   // Called at a negedge with the DUT idle: pulse s for one edge.
   task automatic start_instr(input logic [15:0] instr);
      in = instr;
      s  = 1'b1;
      push_trace(instr);
      @(posedge clk);
      #1;
      s  = 1'b0;
      in = 16'($urandom);
   endtask

   // Called just after the latching edge. Pops and compares one entry per
   // cycle until the expected trace is drained; optionally rewrites `in`
   // after edge sw_edge. Ends on a negedge.
   task automatic follow(input string name, input int exp_lat,
                         input int sw_edge, input logic [15:0] sw_val);
      int   edges;
      int   lat_obs;
      obs_t exp_o, got;
      edges   = 1;
      lat_obs = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         exp_o = sb.pop_front();
         got   = observe();
         n_cmp++;
         if (got !== exp_o) begin
            n_mis++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, edges, got, exp_o);
         end
         if (lat_obs == 0 && w === 1'b1) lat_obs = edges;
         if (sb.size() > 0) begin
            @(posedge clk);
            edges++;
            if (edges == sw_edge) begin
               #1;
               in = sw_val;
            end
         end
      end
      n_cmp++;
      if (lat_obs !== exp_lat) begin
         n_mis++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat_obs, exp_lat);
      end
   endtask

   task automatic run(input string name, input logic [15:0] instr, input int exp_lat);
      start_instr(instr);
      follow(name, exp_lat, 0, 16'h0000);
   endtask

   task automatic check_idle(input string name);
      obs_t exp_o, got;
      exp_o   = '0;
      exp_o.w = 1'b1;
      got     = observe();
      n_cmp++;
      if (got !== exp_o) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, got, exp_o);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      s     = 1'b1;
      in    = 16'hD3FB;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("reset_state");
      s     = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check_idle("after_reset_release");
   endtask

   task automatic test_mov_imm();
      run("mov_imm_neg", 16'hD3FB, 3);   // MOV R3,#-5
      run("mov_imm_pos", 16'hD07F, 3);   // MOV R0,#127
   endtask

   task automatic test_alu();
      run("add",      16'hA140, 6);      // ADD R2,R1,R0
      run("and_same", 16'hB6DE, 6);      // AND R6,R6,R6,ASR
      run("mov_reg",  16'hC0E9, 5);      // MOV R7,R1,LSL#1
      run("mvn",      16'hB895, 5);      // MVN R4,R5,LSR
   endtask

   task automatic test_cmp_illegal();
      run("cmp",       16'hA940, CMP_EN ? 5 : 2);   // CMP R1,R0
      run("ill_opc",   16'hE000, 2);
      run("ill_mov01", 16'hC800, 2);
   endtask

   task automatic test_reset_mid();
      obs_t exp_o, got;
      start_instr(16'hA140);
      // DECODE, GET_A, GET_B
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         exp_o = sb.pop_front();
         got   = observe();
         n_cmp++;
         if (got !== exp_o) begin
            n_mis++;
            $display("FAIL reset_mid pre cycle %0d: got %h expected %h", k + 1, got, exp_o);
         end
         if (k < 2) @(posedge clk);
      end
      sb.delete();
      #1;
      reset = 1'b1;
      #1;
      check_idle("reset_mid_async");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_idle("reset_mid_after_release");
      end
      run("reset_mid_restart", 16'hD3FB, 3);
   endtask

   task automatic test_back_to_back();
      // s held high; `in` goes to junk, then to the second instruction,
      // both while busy. Only the value present when w returns is taken.
      in = 16'hD3FB;
      s  = 1'b1;
      push_trace(16'hD3FB);
      @(posedge clk);
      #1;
      in = 16'hFFFF;
      follow("b2b_first", 3, 2, 16'hC0E9);
      push_trace(16'hC0E9);
      @(posedge clk);
      #1;
      s  = 1'b0;
      in = 16'($urandom);
      follow("b2b_second", 5, 0, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      s     = 1'b0;
      in    = '0;
      test_reset();
      test_mov_imm();
      test_alu();
      test_cmp_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
